// File: rtl/traffic_monitor.sv
// Receive-side checker for the traffic-light phase code: decodes lamps, verifies
// red->green->yellow order and per-phase dwell, and latches a fail-safe red on any violation.
module traffic_monitor #(
    parameter logic [7:0] RED_CYC    = 8'd11,
    parameter logic [7:0] GREEN_CYC  = 8'd11,
    parameter logic [7:0] YELLOW_CYC = 8'd6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sig_in,
    output logic       lamp_r,
    output logic       lamp_y,
    output logic       lamp_g,
    output logic       fault,
    output logic       err_seq,
    output logic       err_dwell,
    output logic       err_code,
    output logic [7:0] err_count,
    output logic [7:0] dwell
);
    localparam logic [1:0] C_RED = 2'b00, C_YEL = 2'b01, C_GRN = 2'b10, C_BAD = 2'b11;

    typedef enum logic [1:0] { SYNC, TRACK, FAULT } state_t;

    state_t     state_q, state_d;
    logic [1:0] s_q, s_d;
    logic       primed_q, primed_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] err_count_q, err_count_d;
    logic       lamp_r_q, lamp_r_d, lamp_y_q, lamp_y_d, lamp_g_q, lamp_g_d;
    logic       err_seq_q, err_seq_d, err_dwell_q, err_dwell_d, err_code_q, err_code_d;

    logic       evt, legal, touches_bad;
    logic [7:0] exp_dwell;

    always_comb begin
        evt         = primed_q && (sig_in != s_q);
        legal       = (s_q == C_RED && sig_in == C_GRN) ||
                      (s_q == C_GRN && sig_in == C_YEL) ||
                      (s_q == C_YEL && sig_in == C_RED);
        touches_bad = (s_q == C_BAD) || (sig_in == C_BAD);
        case (s_q)
            C_RED:   exp_dwell = RED_CYC;
            C_GRN:   exp_dwell = GREEN_CYC;
            C_YEL:   exp_dwell = YELLOW_CYC;
            default: exp_dwell = 8'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        err_seq_d   = 1'b0;
        err_dwell_d = 1'b0;
        err_code_d  = 1'b0;
        s_d         = sig_in;
        primed_d    = 1'b1;

        if (!primed_q || evt)
            dwell_d = 8'd1;
        else if (dwell_q != 8'hFF)
            dwell_d = dwell_q + 8'd1;
        else
            dwell_d = dwell_q;

        // The illegal code wins over every per-state rule, including FAULT exit.
        if (sig_in == C_BAD) begin
            err_code_d = 1'b1;
            state_d    = FAULT;
        end else begin
            case (state_q)
                SYNC: begin
                    if (evt && !touches_bad) begin
                        if (legal) begin
                            state_d = TRACK;
                        end else begin
                            err_seq_d = 1'b1;
                            state_d   = FAULT;
                        end
                    end
                end
                TRACK: begin
                    if (evt && !touches_bad) begin
                        if (!legal) begin
                            err_seq_d = 1'b1;
                            state_d   = FAULT;
                        end else if (dwell_q != exp_dwell) begin
                            err_dwell_d = 1'b1;
                            state_d     = FAULT;
                        end
                    end
                end
                default: begin
                    if (evt && s_q == C_YEL && sig_in == C_RED)
                        state_d = SYNC;
                end
            endcase
        end

        if ((err_seq_d || err_dwell_d || err_code_d) && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
        else
            err_count_d = err_count_q;

        lamp_r_d = 1'b1;
        lamp_y_d = 1'b0;
        lamp_g_d = 1'b0;
        if (state_d != FAULT && sig_in != C_BAD) begin
            lamp_r_d = (sig_in == C_RED);
            lamp_y_d = (sig_in == C_YEL);
            lamp_g_d = (sig_in == C_GRN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            s_q         <= C_RED;
            primed_q    <= 1'b0;
            dwell_q     <= 8'd0;
            err_count_q <= 8'd0;
            err_seq_q   <= 1'b0;
            err_dwell_q <= 1'b0;
            err_code_q  <= 1'b0;
            lamp_r_q    <= 1'b1;
            lamp_y_q    <= 1'b0;
            lamp_g_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            primed_q    <= primed_d;
            dwell_q     <= dwell_d;
            err_count_q <= err_count_d;
            err_seq_q   <= err_seq_d;
            err_dwell_q <= err_dwell_d;
            err_code_q  <= err_code_d;
            lamp_r_q    <= lamp_r_d;
            lamp_y_q    <= lamp_y_d;
            lamp_g_q    <= lamp_g_d;
        end
    end

    assign lamp_r    = lamp_r_q;
    assign lamp_y    = lamp_y_q;
    assign lamp_g    = lamp_g_q;
    assign fault     = (state_q == FAULT);
    assign err_seq   = err_seq_q;
    assign err_dwell = err_dwell_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;
    assign dwell     = dwell_q;
endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: one linear sequence of phase patterns with
// hand-computed expectations checked by immediate assertions.
module tb_traffic_monitor;
    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;
    localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sig_in = R;
    logic       lamp_r, lamp_y, lamp_g, fault, err_seq, err_dwell, err_code;
    logic [7:0] err_count, dwell;

    int checks = 0;
    int errors = 0;

    traffic_monitor dut (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
        .fault(fault), .err_seq(err_seq), .err_dwell(err_dwell), .err_code(err_code),
        .err_count(err_count), .dwell(dwell)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] s);
        sig_in = s;
        @(posedge clk);
        #1;
    endtask

    // Hold one code for n cycles, checking lamps and fault after each edge.
    task automatic run(input logic [1:0] s, input int n, input logic [2:0] lamps, input logic flt);
        for (int i = 0; i < n; i++) begin
            step(s);
            chk("lamps", {lamp_r, lamp_y, lamp_g}, lamps);
            chk("fault", fault, flt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(G);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_lamps", {lamp_r, lamp_y, lamp_g}, L_R);
        chk("rst_fault", fault, 0);
        chk("rst_errs", {err_seq, err_dwell, err_code}, 0);
        chk("rst_count", err_count, 0);
        chk("rst_dwell", dwell, 0);
    endtask

    initial begin
        // Reset state
        step(R);
        chk_reset_vals();
        rst = 1'b0;

        // Clean cycle: lamps follow with one cycle lag, no errors
        run(R, 11, L_R, 0);
        chk("first_dwell", dwell, 11);
        run(G, 11, L_G, 0);
        run(Y, 6, L_Y, 0);
        run(R, 11, L_R, 0);
        run(G, 11, L_G, 0);
        run(Y, 6, L_Y, 0);
        run(R, 1, L_R, 0);
        chk("clean_count", err_count, 0);
        chk("clean_dwell", dwell, 1);

        // Short green in TRACK -> err_dwell
        run(R, 10, L_R, 0);
        run(G, 9, L_G, 0);
        step(Y);
        chk("dw_pulse", err_dwell, 1);
        chk("dw_seq", err_seq, 0);
        chk("dw_fault", fault, 1);
        chk("dw_lamps", {lamp_r, lamp_y, lamp_g}, L_R);
        chk("dw_count", err_count, 1);
        step(Y);
        chk("dw_one_cycle", err_dwell, 0);
        chk("dw_hold_fault", fault, 1);

        // FAULT exit on yellow->red, then SYNC->TRACK on red->green
        step(R);
        chk("exit_fault", fault, 0);
        chk("exit_lamps", {lamp_r, lamp_y, lamp_g}, L_R);
        run(R, 2, L_R, 0);
        step(G);
        chk("resync_errs", {err_seq, err_dwell, err_code}, 0);
        chk("resync_lamp", {lamp_r, lamp_y, lamp_g}, L_G);
        run(G, 4, L_G, 0);
        step(Y);  // 5-cycle green only errors if TRACK was entered
        chk("track_entered", err_dwell, 1);
        chk("track_count", err_count, 2);

        // red->yellow in TRACK -> err_seq only, even though dwell is also wrong
        do_reset();
        chk_reset_vals();
        run(R, 3, L_R, 0);
        run(G, 11, L_G, 0);
        run(Y, 6, L_Y, 0);
        run(R, 4, L_R, 0);
        step(Y);
        chk("seq_pulse", err_seq, 1);
        chk("seq_no_dwell", err_dwell, 0);
        chk("seq_fault", fault, 1);
        chk("seq_lamps", {lamp_r, lamp_y, lamp_g}, L_R);
        chk("seq_count", err_count, 1);
        // Green->yellow while in FAULT is not an exit
        run(G, 2, L_R, 1);
        run(Y, 2, L_R, 1);
        chk("fault_nocheck", err_count, 1);

        // Code 11 for 3 cycles starting in TRACK
        do_reset();
        run(R, 2, L_R, 0);
        run(G, 1, L_G, 0);
        for (int i = 1; i <= 3; i++) begin
            step(X);
            chk("code_pulse", err_code, 1);
            chk("code_seq", err_seq, 0);
            chk("code_lamps", {lamp_r, lamp_y, lamp_g}, L_R);
            chk("code_count", err_count, i);
        end
        chk("code_fault", fault, 1);
        step(R);
        chk("code_clear", err_code, 0);
        chk("code_stay_fault", fault, 1);
        chk("code_count_hold", err_count, 3);

        // Dwell saturation in TRACK: no error at 255, err_dwell at next event
        do_reset();
        run(R, 2, L_R, 0);
        run(G, 300, L_G, 0);
        chk("sat_dwell", dwell, 255);
        chk("sat_noerr", err_count, 0);
        step(Y);
        chk("sat_event", err_dwell, 1);
        chk("sat_reset_dwell", dwell, 1);

        // Sustained code 11: counter saturates, then reset clears everything
        do_reset();
        run(X, 300, L_R, 1);
        chk("cnt_sat", err_count, 255);
        chk("cnt_sat_pulse", err_code, 1);
        do_reset();
        chk_reset_vals();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
